// File: rtl/onchip_mem_arbiter_pkg.sv
// rtl/onchip_mem_arbiter_pkg.sv - shared types and defaults for the two-port on-chip RAM arbiter
// Contents: width defaults, the port identifier type, the arbiter reset value
// and a helper that turns a port id into a one-hot grant vector.
package onchip_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  // last_grant resets to port 1 so that port 0 wins the first contention.
  localparam port_id_t LAST_GRANT_RST = PORT1;

  function automatic logic [1:0] port_onehot(port_id_t p);
    return (p == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - Avalon-MM requester bundle for one arbiter port
// Signals: address, byteenable, read, write, writedata, lock (master -> slave);
//          waitrequest, readdata, readdatavalid (slave -> master).
interface onchip_mem_arbiter_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_arbiter_arb.sv
// rtl/onchip_mem_arbiter_arb.sv - two-way round-robin arbiter with Avalon lock hold
// Ports: clk, reset_n (async, active low); req[1:0], lock[1:0] per requester;
//        grant[1:0] one-hot or zero; winner is the granted port id.
module rr_arb2_lock
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] grant,
  output port_id_t   winner
);

  port_id_t last_grant_q, last_grant_d;
  logic     locked_q, locked_d;
  port_id_t lock_owner_q, lock_owner_d;
  logic     owner_req;

  assign owner_req = (lock_owner_q == PORT1) ? req[1] : req[0];

  // Grant is purely combinational; reset forces no grant so both ports stall.
  always_comb begin
    grant  = 2'b00;
    winner = PORT0;
    if (!reset_n) begin
      grant  = 2'b00;
    end else if (locked_q) begin
      // An idle owner still holds the RAM; the other port keeps waiting.
      if (owner_req) begin
        winner = lock_owner_q;
        grant  = port_onehot(lock_owner_q);
      end
    end else if (req == 2'b11) begin
      winner = (last_grant_q == PORT0) ? PORT1 : PORT0;
      grant  = port_onehot(winner);
    end else if (req[0]) begin
      winner = PORT0;
      grant  = 2'b01;
    end else if (req[1]) begin
      winner = PORT1;
      grant  = 2'b10;
    end
  end

  // State moves only on a granted transfer, so the lock is released only by
  // the owner's own transfer with lock deasserted.
  always_comb begin
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    if (grant != 2'b00) begin
      last_grant_d = winner;
      locked_d     = (winner == PORT1) ? lock[1] : lock[0];
      lock_owner_d = winner;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= LAST_GRANT_RST;
      locked_q     <= 1'b0;
      lock_owner_q <= PORT0;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - shares one single-port on-chip RAM between two Avalon-MM masters
// Ports: clk, reset_n (async, active low);
//        s0_*/s1_*: address, byteenable, read, write, writedata, lock in;
//                   waitrequest, readdata, readdatavalid out;
//        mem_*: address, byteenable, chipselect, write, writedata out; readdata in.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] s0_address,
  input  logic [BE_W-1:0]   s0_byteenable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  input  logic              s0_lock,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  input  logic              s1_lock,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] grant;
  port_id_t   winner;
  logic       any_grant;
  logic       granted_read;

  logic       rd_pend_q, rd_pend_d;
  port_id_t   rd_owner_q, rd_owner_d;

  assign req       = {s1_read | s1_write, s0_read | s0_write};
  assign lock      = {s1_lock, s0_lock};
  assign any_grant = |grant;

  rr_arb2_lock u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .lock    (lock),
    .grant   (grant),
    .winner  (winner)
  );

  // Waitrequest depends only on requests, grant and reset, never on RAM data.
  assign s0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
  assign s1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

  // Port 0 drives the RAM bus by default; chipselect/write qualify it.
  always_comb begin
    mem_address    = s0_address;
    mem_byteenable = s0_byteenable;
    mem_writedata  = s0_writedata;
    mem_write      = 1'b0;
    mem_chipselect = any_grant;
    granted_read   = 1'b0;
    if (grant[1]) begin
      mem_address    = s1_address;
      mem_byteenable = s1_byteenable;
      mem_writedata  = s1_writedata;
      mem_write      = s1_write;
      granted_read   = s1_read & ~s1_write;
    end else if (grant[0]) begin
      mem_write      = s0_write;
      granted_read   = s0_read & ~s0_write;
    end
  end

  // One-deep return pipeline: the RAM answers exactly one cycle after issue.
  // A read+write request is treated as a write, so it produces no return.
  always_comb begin
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (granted_read) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = winner;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= PORT0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign s0_readdatavalid = rd_pend_q & (rd_owner_q == PORT0);
  assign s1_readdatavalid = rd_pend_q & (rd_owner_q == PORT1);
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench for onchip_mem_arbiter with RAM model
module tb_onchip_mem_arbiter;
  import onchip_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct {
    bit              rd;
    bit              wr;
    bit              lk;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [BW-1:0]   be;
  } req_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_address       (p0.address),
    .s0_byteenable    (p0.byteenable),
    .s0_read          (p0.read),
    .s0_write         (p0.write),
    .s0_writedata     (p0.writedata),
    .s0_lock          (p0.lock),
    .s0_waitrequest   (p0.waitrequest),
    .s0_readdata      (p0.readdata),
    .s0_readdatavalid (p0.readdatavalid),
    .s1_address       (p1.address),
    .s1_byteenable    (p1.byteenable),
    .s1_read          (p1.read),
    .s1_write         (p1.write),
    .s1_writedata     (p1.writedata),
    .s1_lock          (p1.lock),
    .s1_waitrequest   (p1.waitrequest),
    .s1_readdata      (p1.readdata),
    .s1_readdatavalid (p1.readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata)
  );

  // Single-port RAM: registered address, unregistered output.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_addr_q <= mem_address;
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rdata;
  int m_last  = 1;
  int m_owner = -1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic req_t idle();
    req_t r;
    r.rd = 0; r.wr = 0; r.lk = 0; r.addr = '0; r.data = '0; r.be = '0;
    return r;
  endfunction

  function automatic req_t mk(bit rd, bit wr, bit lk, int addr, logic [DW-1:0] data, logic [BW-1:0] be);
    req_t r;
    r.rd = rd; r.wr = wr; r.lk = lk; r.addr = AW'(addr); r.data = data; r.be = be;
    return r;
  endfunction

  // One bus cycle: drive after the edge, check at the falling edge against
  // the fairness/lock rules and update the shadow memory and scoreboard.
  task automatic cycle(input req_t a, input req_t b, input bit rst_v, output int win);
    req_t r[2];
    bit   q[2];
    logic [DW-1:0] mask;
    bit   w_exp;
    exp_t e;
    r[0] = a; r[1] = b;
    @(posedge clk); #1;
    reset_n = rst_v;
    p0.read = a.rd; p0.write = a.wr; p0.lock = a.lk;
    p0.address = a.addr; p0.writedata = a.data; p0.byteenable = a.be;
    p1.read = b.rd; p1.write = b.wr; p1.lock = b.lk;
    p1.address = b.addr; p1.writedata = b.data; p1.byteenable = b.be;
    if (!rst_v) begin
      m_last = 1; m_owner = -1; exp_q.delete();
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) q[p] = r[p].rd | r[p].wr;
    win = -1;
    if (!rst_v)                win = -1;
    else if (m_owner >= 0)     win = q[m_owner] ? m_owner : -1;
    else if (q[0] && q[1])     win = 1 - m_last;
    else if (q[0])             win = 0;
    else if (q[1])             win = 1;
    w_exp = 0;
    if (win >= 0) w_exp = r[win].wr;
    check("wait0", p0.waitrequest, !rst_v || (q[0] && win != 0));
    check("wait1", p1.waitrequest, !rst_v || (q[1] && win != 1));
    check("mem_cs", mem_chipselect, win >= 0);
    check("mem_write", mem_write, w_exp);
    if (!rst_v) check("rst_rdv", {p1.readdatavalid, p0.readdatavalid}, 0);
    if (win >= 0) begin
      check("mem_addr", mem_address, r[win].addr);
      if (r[win].wr) begin
        check("mem_wdata", mem_writedata, r[win].data);
        check("mem_be", mem_byteenable, r[win].be);
        for (int k = 0; k < BW; k++) mask[8*k +: 8] = {8{r[win].be[k]}};
        ref_mem[r[win].addr] = (ref_mem[r[win].addr] & ~mask) | (r[win].data & mask);
      end else begin
        e.port = win; e.data = ref_mem[r[win].addr]; e.cyc = cyc;
        exp_q.push_back(e);
      end
      m_last  = win;
      m_owner = r[win].lk ? win : -1;
    end
  endtask

  // Single-port transfer that holds its request until granted.
  task automatic xfer(input int port, input req_t r);
    int win = -1;
    int n = 0;
    while (win != port && n < 20) begin
      cycle(port == 0 ? r : idle(), port == 1 ? r : idle(), 1'b1, win);
      n++;
    end
    if (win != port) check("xfer_timeout", win, port);
  endtask

  task automatic idles(input int n);
    int w;
    for (int i = 0; i < n; i++) cycle(idle(), idle(), 1'b1, w);
  endtask

  // Monitor: pops the scoreboard whenever a port presents read data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (p0.readdatavalid || p1.readdatavalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdv", {p1.readdatavalid, p0.readdatavalid}, 0);
        end else begin
          e = exp_q.pop_front();
          check("rdv_both", p0.readdatavalid & p1.readdatavalid, 0);
          check("rdv_port", p1.readdatavalid ? 1 : 0, e.port);
          check("rdv_latency", cyc, e.cyc + 1);
          last_rdata = p0.readdatavalid ? p0.readdata : p1.readdata;
          check("rdata", last_rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
        e = exp_q.pop_front();
        check("missing_rdv", 0, 1 + e.port);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    req_t a, b;
    p0.read = 0; p0.write = 0; p0.lock = 0; p0.address = '0; p0.writedata = '0; p0.byteenable = '0;
    p1.read = 0; p1.write = 0; p1.lock = 0; p1.address = '0; p1.writedata = '0; p1.byteenable = '0;

    // Reset with both ports requesting: everything stalled, nothing issued.
    for (int i = 0; i < 2; i++) cycle(mk(1,0,0,16,0,0), mk(1,0,0,17,0,0), 1'b0, w);
    idles(1);

    // Preload the random address window.
    for (int i = 16; i < 32; i++) xfer(1, mk(0,1,0,i,$urandom,4'hF));

    // Write then read back on port 0.
    xfer(0, mk(0,1,0,5,32'hDEADBEEF,4'hF));
    xfer(0, mk(1,0,0,5,0,4'hF));
    idles(2);
    check("t1_rdata", last_rdata, 32'hDEADBEEF);

    // Contention after reset strictly alternates starting with port 0.
    cycle(idle(), idle(), 1'b0, w);
    for (int i = 0; i < 6; i++) begin
      cycle(mk(1,0,0,16+i,0,0), mk(1,0,0,20+i,0,0), 1'b1, w);
      check("alt_wait0", p0.waitrequest, i % 2);
      check("alt_wait1", p1.waitrequest, 1 - (i % 2));
    end
    idles(1);

    // Port 1 locks across three reads with an idle gap.
    cycle(idle(), mk(1,0,1,16,0,0), 1'b1, w);
    check("lk_wait1", p1.waitrequest, 0);
    cycle(mk(1,0,0,17,0,0), idle(), 1'b1, w);
    check("lk_gap_wait0", p0.waitrequest, 1);
    cycle(mk(1,0,0,17,0,0), mk(1,0,1,18,0,0), 1'b1, w);
    check("lk2_wait0", p0.waitrequest, 1);
    cycle(mk(1,0,0,17,0,0), mk(1,0,0,19,0,0), 1'b1, w);
    check("lk3_wait0", p0.waitrequest, 1);
    check("lk3_wait1", p1.waitrequest, 0);
    cycle(mk(1,0,0,17,0,0), idle(), 1'b1, w);
    check("lk_rel_wait0", p0.waitrequest, 0);
    idles(1);

    // Partial byteenable write merge.
    xfer(0, mk(0,1,0,9,32'hAAAAAAAA,4'hF));
    xfer(0, mk(0,1,0,9,32'h12345678,4'h3));
    xfer(0, mk(1,0,0,9,0,0));
    idles(2);
    check("be_rdata", last_rdata, 32'hAAAA5678);

    // Reset in the cycle after a read grant drops the return.
    xfer(0, mk(1,0,0,16,0,0));
    cycle(mk(1,0,0,16,0,0), mk(1,0,0,17,0,0), 1'b0, w);
    check("rst_cs", mem_chipselect, 0);
    cycle(mk(1,0,0,16,0,0), mk(1,0,0,17,0,0), 1'b1, w);
    check("rst_first_wait0", p0.waitrequest, 0);
    check("rst_first_wait1", p1.waitrequest, 1);
    idles(2);

    // Read and write together: the write wins, no return.
    xfer(0, mk(1,1,0,7,32'h1,4'hF));
    check("rw_mem_write", mem_write, 1);
    idles(2);
    xfer(0, mk(1,0,0,7,0,0));
    idles(2);
    check("rw_rdata", last_rdata, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      a = idle(); b = idle();
      if ($urandom_range(9) < 7) begin
        a.wr = $urandom_range(2) == 0; a.rd = !a.wr || ($urandom_range(19) == 0);
      end
      if ($urandom_range(9) < 7) begin
        b.wr = $urandom_range(2) == 0; b.rd = !b.wr || ($urandom_range(19) == 0);
      end
      a.lk = $urandom_range(4) == 0; b.lk = $urandom_range(4) == 0;
      a.addr = AW'(16 + $urandom_range(15)); b.addr = AW'(16 + $urandom_range(15));
      a.data = $urandom; b.data = $urandom;
      a.be = 4'($urandom); b.be = 4'($urandom);
      cycle(a, b, 1'b1, w);
    end
    idles(3);
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port Avalon-MM front end that shares one single-port 1024x32 on-chip RAM (registered address, unregistered output, 1-cycle read latency) between two masters, typically the Nios II data master and a DMA/streaming engine. Sits between the interconnect and the RAM instance. Grants one transfer per cycle with round-robin fairness and Avalon `lock` support. Returns pipelined read data tagged to the issuing port.

## Interface
Parameters:
- `ADDR_W`, 10, word address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `BE_W`, DATA_W/8, byteenable width; derived, not overridden.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s0_address`, `s1_address`  in  ADDR_W  word address per requester.
- `s0_byteenable`, `s1_byteenable`  in  BE_W  byte lanes for writes; ignored on reads.
- `s0_read`, `s1_read`  in  1  read request.
- `s0_write`, `s1_write`  in  1  write request.
- `s0_writedata`, `s1_writedata`  in  DATA_W  write data.
- `s0_lock`, `s1_lock`  in  1  Avalon lock; holds the grant across transfers.
- `s0_waitrequest`, `s1_waitrequest`  out  1  stall for the requesting port.
- `s0_readdata`, `s1_readdata`  out  DATA_W  read data.
- `s0_readdatavalid`, `s1_readdatavalid`  out  1  read data qualifier.
- `mem_address`  out  ADDR_W  to RAM.
- `mem_byteenable`  out  BE_W  to RAM.
- `mem_chipselect`  out  1  to RAM.
- `mem_write`  out  1  to RAM.
- `mem_writedata`  out  DATA_W  to RAM.
- `mem_readdata`  in  DATA_W  from RAM, valid one cycle after a read is issued.

## Operation
- Request per port: `req_i = s_i_read | s_i_write`.
- If both `read` and `write` are asserted on one port, this is illegal Avalon; the write is performed and the read is dropped.
- Grant is combinational each cycle:
  - If `locked`, the port named by `lock_owner` wins; the other port waits even if the owner is idle.
  - Else with one requester, that port wins.
  - Else with both requesting, the port that is not `last_grant` wins.
- Granted port:
  - `waitrequest=0`.
  - Its address, byteenable, writedata and write are driven to `mem_*`.
  - `mem_chipselect=1`.
- Non-granted requesting port: `waitrequest=1`.
- Idle port: `waitrequest=0`.
- No grant: `mem_chipselect=0` and `mem_write=0`; other `mem_*` outputs hold port 0 values (don't-care).
- Registered state updates at each clock edge with a grant:
  - `last_grant <= winner`.
  - `locked <= s_winner_lock` and `lock_owner <= winner`.
  - If granted and the transfer is a read, `rd_pend <= 1` and `rd_owner <= winner`; otherwise `rd_pend <= 0`.
- Lock release occurs only on a granted transfer with `lock=0` from the owner. Owner idle cycles do not release the lock.
- Read return: `s_i_readdatavalid = rd_pend & (rd_owner==i)`. Both `s_i_readdata` outputs are driven from `mem_readdata` directly.
- Writes have no response phase.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `last_grant=1`, so port 0 wins the first contention.
  - `locked=0`, `lock_owner=0`, `rd_pend=0`, `rd_owner=0`.
- While `reset_n=0`:
  - Both `waitrequest=1`.
  - Both `readdatavalid=0`.
  - `mem_chipselect=0`, `mem_write=0`.
- Read latency is exactly 1 cycle: a read granted in cycle T returns `readdatavalid` in T+1.
- Throughput: back-to-back reads give one read per cycle, and ports can be interleaved.
- A write granted in T updates the RAM at the T/T+1 edge.
- A read of the same address granted in T+1 returns the new data.
- Reset mid-read: `rd_pend` clears immediately, and no `readdatavalid` is produced for the lost read.
- Reset mid-lock: the lock is dropped.
- Contention with no lock strictly alternates 0,1,0,1.
- No combinational path from `mem_readdata` to any `waitrequest`.

## Structure
- Package `onchip_arb_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults.
  - `port_id_t` (1-bit enum `PORT0`/`PORT1`).
  - Reset constant `LAST_GRANT_RST = PORT1`.
- Sub-module `rr_arb2_lock` contains `last_grant`, `locked`, `lock_owner` and the grant logic.
  - Inputs: `req[1:0]`, `lock[1:0]`.
  - Outputs: `grant[1:0]` (one-hot or zero), `winner`.
- The top level instantiates `rr_arb2_lock`. It also owns the `mem_*` mux and the `rd_pend`/`rd_owner` return pipeline.

## Test plan
- Reset, then s0 writes 0xDEADBEEF at address 5 with byteenable 0xF; s0 then reads address 5. Expect `s0_readdatavalid` one cycle after the read grant with data 0xDEADBEEF; `s1_readdatavalid` stays 0.
- s0 and s1 both read continuously for 6 cycles. Expect grants 0,1,0,1,0,1, each port's `waitrequest` high on alternate cycles, and each `readdatavalid` tagged to the correct port.
- s1 asserts `lock` across 3 reads with an idle gap, while s0 requests throughout. Expect s0 stalled until s1's transfer with `lock=0` is granted; s0 is granted the following cycle.
- Write byteenable 0x3 with data 0x12345678 over stored 0xAAAAAAAA, then read. Expect 0xAAAA5678.
- Assert `reset_n=0` in the cycle after a read grant. Expect no `readdatavalid`, `mem_chipselect=0` and both `waitrequest=1`; after release, port 0 wins the first contention.
- s0 asserts read and write together (address 7, data 0x1). Expect `mem_write=1`, no `readdatavalid`, and address 7 then reads 0x1.
